// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame
// geometry, line levels and the even-parity helper.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int LAST_BIT  = DATA_BITS - 1;

    // Serial line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;

    // True when data ones plus the parity bit add up to an even count.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                            input logic                 parity_bit);
        return ~(^{data, parity_bit});
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, valid flag,
// acknowledge and error flags.
// Optional feature macro: UART_RX_PARITY_EN adds the ParityErr signal.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] RxData;
    logic                 RxValid;
    logic                 RxRead;
    logic                 FramingErr;
    logic                 Overrun;
`ifdef UART_RX_PARITY_EN
    logic                 ParityErr;

    modport master (output RxData, RxValid, FramingErr, Overrun, ParityErr,
                    input  RxRead);
    modport slave  (input  RxData, RxValid, FramingErr, Overrun, ParityErr,
                    output RxRead);
`else
    modport master (output RxData, RxValid, FramingErr, Overrun,
                    input  RxRead);
    modport slave  (input  RxData, RxValid, FramingErr, Overrun,
                    output RxRead);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit. Both flops
// load RESET_VAL on a synchronous, active-high reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make both flops sample old values on
        // the same edge; blocking here would collapse the chain to one flop.
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 with parity) sampled mid-bit using an
// external OVERSAMPLE x baud tick. OVERSAMPLE must be even and >= 4.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and the stop bit and drives ParityErr.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sampleTick,
    input  logic       RxIn,
    uart_rx_if.master  rx_if
);

    localparam int               CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(LAST_BIT);

    logic                 rx_sync;

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_bit_q;

    logic [DATA_BITS-1:0] rx_data_q,     rx_data_d;
    logic                 rx_valid_q,    rx_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q,     overrun_d;
    logic                 parity_err_q,  parity_err_d;
    logic                 stop_sample;

    sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (RxIn),
        .q_o   (rx_sync)
    );

    // Frame sequencer: advances only on sample ticks, samples each bit at its centre.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
        end else if (sampleTick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_sync == LINE_START) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        if (rx_sync != LINE_START) begin
                            state_q <= ST_IDLE;       // glitch, not a real start bit
                        end else begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_sync;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q        <= '0;
                        parity_bit_q <= rx_sync;
                        state_q      <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stop_sample = sampleTick && (state_q == ST_STOP) && (cnt_q == FULL_LAST);

    // Next-state of the consumer-facing registers: delivery, acknowledge and error flags.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        framing_err_d = 1'b0;
        parity_err_d  = 1'b0;
        if (rx_if.RxRead) begin
            rx_valid_d = 1'b0;
        end
        if (stop_sample) begin
            if (rx_sync == LINE_STOP) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_if.RxRead) begin
                    overrun_d = 1'b1;                 // unread byte lost
                end
            end else begin
                framing_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = !even_parity_ok(shift_q, parity_bit_q);
`endif
        end
    end

    // Register the consumer-facing outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign rx_if.RxData     = rx_data_q;
    assign rx_if.RxValid    = rx_valid_q;
    assign rx_if.FramingErr = framing_err_q;
    assign rx_if.Overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.ParityErr  = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sampleTick pulses per bit period; SHALL be an even value of at least 4.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 sampleTick  input  1  one-clock enable pulse at OVERSAMPLE x baud; all receive sequencing SHALL advance only on cycles where it is high.
REQ-005 RxIn  input  1  asynchronous serial line; idle high, start low, 8 data bits LSB first, stop high.
REQ-006 RxRead  input  1  consumer acknowledge; clears RxValid.
REQ-007 RxData  output  8  last correctly framed byte.
REQ-008 RxValid  output  1  RxData holds an unread byte.
REQ-009 FramingErr  output  1  one-clock pulse when the stop bit samples low.
REQ-010 Overrun  output  1  sticky flag: an unread byte was overwritten.

Function
REQ-011 RxIn SHALL pass through a 2-flop synchronizer before any use; both flops take the value 1 on reset.
REQ-012 States: IDLE, START, DATA, STOP (plus PARITY, see REQ-025); the tick counter is ceil(log2(OVERSAMPLE)) bits wide and the bit index is 3 bits wide.
REQ-013 IDLE: on a tick with the synced line low, the block SHALL go to START and clear the tick counter.
REQ-014 START: at tick count OVERSAMPLE/2-1 the block SHALL sample the line. If the sample is high, it is a false start and the block SHALL return to IDLE. If low, it SHALL go to DATA and clear the counter and bit index.
REQ-015 DATA: every OVERSAMPLE ticks the block SHALL sample into shift bit [index], LSB first. After index 7 it SHALL go to STOP.
REQ-016 STOP: after OVERSAMPLE ticks the block SHALL sample the line.
  - Sample high: load RxData, set RxValid.
  - Sample low: discard the byte, pulse FramingErr, leave RxData and RxValid unchanged.
  - In both cases, go to IDLE on the same edge.
REQ-017 Latency: RxValid SHALL rise on the clock edge of the tick that is (OVERSAMPLE/2 + 9*OVERSAMPLE) ticks after the first low-sampled tick in IDLE.
REQ-018 RxRead high SHALL clear RxValid on the next edge; RxRead while RxValid is low SHALL have no effect.
REQ-019 Frame completion while RxValid=1 and RxRead=0 SHALL overwrite RxData, keep RxValid=1, and set Overrun.
REQ-020 Frame completion in the same cycle as RxRead=1 SHALL load the new byte with RxValid=1 and SHALL NOT set Overrun.
REQ-021 Overrun SHALL clear only on reset.
REQ-022 Cycles with sampleTick low SHALL hold state, counters and the shift register; RxRead handling is independent of sampleTick.

Reset
REQ-023 Reset SHALL take precedence over all other inputs, regardless of sampleTick, with effect on the next edge:
  - state = IDLE; counter, index and shift register = 0.
  - RxData = 8'h00; RxValid = 0; FramingErr = 0; Overrun = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no RxValid and no FramingErr. Reception SHALL restart on the first low tick after reset is released.

Configuration
REQ-025 With UART_RX_PARITY_EN defined:
  - Output ParityErr (1 bit) SHALL exist.
  - A PARITY state SHALL sit between DATA and STOP and sample one bit period.
  - Even parity is checked: data ones plus the parity bit must be even.
  - On a mismatch, ParityErr SHALL pulse one clock at stop-bit time; the byte is still delivered per REQ-016.
  - Latency in REQ-017 becomes OVERSAMPLE/2 + 10*OVERSAMPLE.
REQ-026 Without UART_RX_PARITY_EN: no ParityErr port, no PARITY state, and the 10-bit frame of REQ-005.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state enum, DATA_BITS=8, LAST_BIT=7, and the idle/start/stop line levels for reuse by the transmitter.
REQ-028 The synchronizer SHALL be a sub-module named sync_2ff.

Verification
REQ-029 Frame 0xA5 at OVERSAMPLE=16, RxRead low: RxData=8'hA5 and RxValid=1 at tick 152 after the start edge; FramingErr and Overrun stay 0.
REQ-030 Line low for 4 ticks, then high: no state leaves IDLE beyond START, and RxValid stays 0.
REQ-031 Frame 0x3C with the stop bit low: FramingErr pulses exactly 1 clock, RxValid=0, and RxData stays at its prior value.
REQ-032 Frames 0x11 then 0x22 with no RxRead: RxData=8'h22, RxValid=1, Overrun=1. Then pulse RxRead: RxValid=0 and Overrun stays 1.
REQ-033 Reset asserted during data bit 4 of 0x5A: all outputs are 0 on the next edge. A subsequent frame 0x81 is received correctly.
REQ-034 With UART_RX_PARITY_EN: byte 0x03 with parity bit 1 gives ParityErr pulse and RxData=8'h03. Byte 0x03 with parity bit 0 gives no ParityErr.
